// File: rtl/e2e_csr_pkg.sv
// e2e_csr_pkg
// Shared definitions for the eth_e2e AFU MMIO responder:
//   - the minimal CCI-P Rx / MMIO header types the responder consumes
//   - 64-bit CSR index map and CTRL bit positions
//   - indirect management FSM state encoding
//   - read-back pattern used when an indirect read times out
package e2e_csr_pkg;

  typedef logic [8:0] t_ccip_tid;

  typedef struct packed {
    logic [15:0] address;  // dword address
    logic [1:0]  length;   // 0: 32-bit access, otherwise 64-bit
    logic        rsvd;
    t_ccip_tid   tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  localparam logic [14:0] E2E_CSR_DFH      = 15'd0;
  localparam logic [14:0] E2E_CSR_AFU_ID_L = 15'd1;
  localparam logic [14:0] E2E_CSR_AFU_ID_H = 15'd2;
  localparam logic [14:0] E2E_CSR_CTRL     = 15'd6;
  localparam logic [14:0] E2E_CSR_WDATA    = 15'd7;
  localparam logic [14:0] E2E_CSR_RDATA    = 15'd8;
  localparam logic [14:0] E2E_CSR_SCRATCH  = 15'd9;

  localparam int unsigned CTRL_WR_CMD_BIT  = 16;
  localparam int unsigned CTRL_RD_CMD_BIT  = 17;
  localparam int unsigned CTRL_TIMEOUT_BIT = 30;
  localparam int unsigned CTRL_BUSY_BIT    = 31;

  typedef enum logic [1:0] {
    MGMT_IDLE    = 2'd0,
    MGMT_WR      = 2'd1,
    MGMT_RD_REQ  = 2'd2,
    MGMT_RD_WAIT = 2'd3
  } t_mgmt_state;

  localparam logic [31:0] TIMEOUT_PATTERN = 32'hDEAD_BEEF;

  // 32-bit reads return the selected dword zero-extended.
  function automatic logic [63:0] dword_view(input logic [63:0] val,
                                             input logic is_32,
                                             input logic hi);
    if (!is_32) return val;
    return hi ? {32'h0, val[63:32]} : {32'h0, val[31:0]};
  endfunction

endpackage

// File: rtl/e2e_mgmt_indirect_fsm.sv
// e2e_mgmt_indirect_fsm
// Sequences single indirect write/read transactions on the 32-bit
// management bus and holds the RDATA mailbox and timeout status.
// Optional feature macro: E2E_MGMT_TIMEOUT_EN (read timeout counter).
//
// state        | meaning
// -------------+---------------------------------------------------
// MGMT_IDLE    | no command in flight, accepts start_wr / start_rd
// MGMT_WR      | mgmt_wr strobe with address and write data
// MGMT_RD_REQ  | mgmt_rd strobe with address
// MGMT_RD_WAIT | waiting for mgmt_rvalid (or timeout when enabled)
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start_wr/rd    command edges from the CTRL register
//   ctrl_addr      indirect address, wdata indirect write data
//   mgmt_*         management bus strobes and read return
//   rdata          RDATA mailbox, busy / timeout_err CTRL status bits
module e2e_mgmt_indirect_fsm
  import e2e_csr_pkg::*;
#(
  parameter int unsigned MGMT_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_wr,
  input  logic        start_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] wdata,
  output logic        mgmt_wr,
  output logic        mgmt_rd,
  output logic [15:0] mgmt_addr,
  output logic [31:0] mgmt_wdata,
  input  logic [31:0] mgmt_rdata,
  input  logic        mgmt_rvalid,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        timeout_err
);

  t_mgmt_state state_q, state_d;
  logic        tmo_hit;

`ifdef E2E_MGMT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MGMT_TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  // Loaded while the read strobe goes out, so RD_WAIT lasts exactly
  // MGMT_TIMEOUT cycles before giving up.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state_q == MGMT_RD_REQ) begin
      tmo_cnt <= CW'(MGMT_TIMEOUT - 1);
    end else if (state_q == MGMT_RD_WAIT && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - CW'(1);
    end
  end

  assign tmo_hit = (state_q == MGMT_RD_WAIT) && (tmo_cnt == '0);
`else
  logic unused_timeout;
  assign unused_timeout = ^MGMT_TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= MGMT_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mgmt_wr    = 1'b0;
    mgmt_rd    = 1'b0;
    mgmt_addr  = '0;
    mgmt_wdata = '0;
    case (state_q)
      MGMT_IDLE: begin
        if (start_wr)      state_d = MGMT_WR;
        else if (start_rd) state_d = MGMT_RD_REQ;
      end
      MGMT_WR: begin
        mgmt_wr    = 1'b1;
        mgmt_addr  = ctrl_addr;
        mgmt_wdata = wdata;
        state_d    = MGMT_IDLE;
      end
      MGMT_RD_REQ: begin
        mgmt_rd   = 1'b1;
        mgmt_addr = ctrl_addr;
        state_d   = MGMT_RD_WAIT;
      end
      MGMT_RD_WAIT: begin
        if (mgmt_rvalid || tmo_hit) state_d = MGMT_IDLE;
      end
      default: state_d = MGMT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata       <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Error flag survives until the host launches the next command.
      if (state_q == MGMT_IDLE && (start_wr || start_rd)) timeout_err <= 1'b0;
      if (state_q == MGMT_RD_WAIT) begin
        if (mgmt_rvalid) begin
          rdata <= mgmt_rdata;
        end else if (tmo_hit) begin
          rdata       <= TIMEOUT_PATTERN;
          timeout_err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != MGMT_IDLE);

endmodule

// File: rtl/e2e_mmio_csr_responder.sv
// e2e_mmio_csr_responder
// AFU-side CCI-P MMIO responder: decodes c0 MMIO reads/writes, owns the
// DFH/AFU ID/scratch registers and the CTRL/WDATA/RDATA mailbox that
// drives the indirect management bus. Reads return on c2 two cycles
// after the request, fully pipelined.
// Optional feature macro: E2E_MGMT_TIMEOUT_EN (passed to the mgmt FSM).
//
// Ports:
//   pClk, pck_cp2af_softReset   clock, synchronous active-high reset
//   pck_cp2af_sRx               CCI-P Rx (c0 MMIO fields only)
//   mmio_rsp_valid/tid/data     c2 MMIO read response
//   mgmt_wr/rd/addr/wdata       indirect management bus request
//   mgmt_rdata/rvalid           indirect management bus read return
module e2e_mmio_csr_responder
  import e2e_csr_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L     = 64'h0,
  parameter logic [63:0] AFU_ID_H     = 64'h0,
  parameter logic [63:0] DFH_VALUE    = 64'h1000_0000_0000_0000,
  parameter int unsigned MGMT_TIMEOUT = 1024
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset,
  input  t_if_ccip_Rx pck_cp2af_sRx,
  output logic        mmio_rsp_valid,
  output t_ccip_tid   mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  output logic        mgmt_wr,
  output logic        mgmt_rd,
  output logic [15:0] mgmt_addr,
  output logic [31:0] mgmt_wdata,
  input  logic [31:0] mgmt_rdata,
  input  logic        mgmt_rvalid
);

  t_ccip_c0_ReqMmioHdr hdr;
  logic [14:0] idx;
  logic        is_32, hi, rd_en, wr_en, lo_we;
  logic [63:0] wr_data;

  assign hdr     = pck_cp2af_sRx.c0.hdr;
  assign idx     = hdr.address[15:1];
  assign is_32   = (hdr.length == 2'b00);
  assign hi      = hdr.address[0];
  assign rd_en   = pck_cp2af_sRx.c0.mmioRdValid;
  assign wr_en   = pck_cp2af_sRx.c0.mmioWrValid;
  assign wr_data = pck_cp2af_sRx.c0.data[63:0];
  // 32-bit CSRs only react to writes that cover dword 0.
  assign lo_we   = wr_en && (!is_32 || !hi);

  logic unused_rx;
  assign unused_rx = ^{pck_cp2af_sRx.c0TxAlmFull, pck_cp2af_sRx.c1TxAlmFull,
                       hdr.rsvd, pck_cp2af_sRx.c0.data[511:64],
                       pck_cp2af_sRx.c0.rspValid};

  logic [63:0] scratch;
  logic [15:0] ctrl_addr;
  logic        ctrl_wr, ctrl_rd;
  logic [31:0] wdata_q, rdata;
  logic        busy, timeout_err;
  logic        ctrl_we, start_wr, start_rd;

  assign ctrl_we  = lo_we && (idx == E2E_CSR_CTRL);
  // Commands fire on the 0->1 edge of the stored bit; write wins a tie.
  assign start_wr = ctrl_we && wr_data[CTRL_WR_CMD_BIT] && !ctrl_wr;
  assign start_rd = ctrl_we && wr_data[CTRL_RD_CMD_BIT] && !ctrl_rd && !start_wr;

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      scratch   <= '0;
      ctrl_addr <= '0;
      ctrl_wr   <= 1'b0;
      ctrl_rd   <= 1'b0;
      wdata_q   <= '0;
    end else begin
      if (wr_en && idx == E2E_CSR_SCRATCH) begin
        if (!is_32)  scratch          <= wr_data;
        else if (hi) scratch[63:32]   <= wr_data[31:0];
        else         scratch[31:0]    <= wr_data[31:0];
      end
      if (ctrl_we) begin
        ctrl_addr <= wr_data[15:0];
        ctrl_wr   <= wr_data[CTRL_WR_CMD_BIT];
        ctrl_rd   <= wr_data[CTRL_RD_CMD_BIT];
      end
      if (lo_we && idx == E2E_CSR_WDATA) wdata_q <= wr_data[31:0];
    end
  end

  logic [63:0] reg_val;

  // Uses pre-write register values, so a same-cycle read sees old data.
  always_comb begin
    reg_val = '0;
    case (idx)
      E2E_CSR_DFH:      reg_val = DFH_VALUE;
      E2E_CSR_AFU_ID_L: reg_val = AFU_ID_L;
      E2E_CSR_AFU_ID_H: reg_val = AFU_ID_H;
      E2E_CSR_CTRL:     reg_val = {32'h0, busy, timeout_err, 12'h0,
                                   ctrl_rd, ctrl_wr, ctrl_addr};
      E2E_CSR_WDATA:    reg_val = {32'h0, wdata_q};
      E2E_CSR_RDATA:    reg_val = {32'h0, rdata};
      E2E_CSR_SCRATCH:  reg_val = scratch;
      default:          reg_val = '0;
    endcase
  end

  logic        s1_valid;
  t_ccip_tid   s1_tid;
  logic [63:0] s1_data;

  always_ff @(posedge pClk) begin
    if (pck_cp2af_softReset) begin
      s1_valid       <= 1'b0;
      s1_tid         <= '0;
      s1_data        <= '0;
      mmio_rsp_valid <= 1'b0;
      mmio_rsp_tid   <= '0;
      mmio_rsp_data  <= '0;
    end else begin
      s1_valid       <= rd_en;
      s1_tid         <= rd_en ? hdr.tid : '0;
      s1_data        <= rd_en ? dword_view(reg_val, is_32, hi) : '0;
      mmio_rsp_valid <= s1_valid;
      mmio_rsp_tid   <= s1_tid;
      mmio_rsp_data  <= s1_data;
    end
  end

  e2e_mgmt_indirect_fsm #(
    .MGMT_TIMEOUT(MGMT_TIMEOUT)
  ) u_mgmt_fsm (
    .clk         (pClk),
    .rst         (pck_cp2af_softReset),
    .start_wr    (start_wr),
    .start_rd    (start_rd),
    .ctrl_addr   (ctrl_addr),
    .wdata       (wdata_q),
    .mgmt_wr     (mgmt_wr),
    .mgmt_rd     (mgmt_rd),
    .mgmt_addr   (mgmt_addr),
    .mgmt_wdata  (mgmt_wdata),
    .mgmt_rdata  (mgmt_rdata),
    .mgmt_rvalid (mgmt_rvalid),
    .rdata       (rdata),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

endmodule

// File: tb/tb_e2e_mmio_csr_responder.sv
// Directed bench for e2e_mmio_csr_responder. A small management-bus
// model counts strobes and answers mgmt_rd after rsp_delay cycles.
module tb_e2e_mmio_csr_responder;
  import e2e_csr_pkg::*;

  localparam logic [63:0] ID_L = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] ID_H = 64'hfedc_ba98_7654_3210;
  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  t_if_ccip_Rx rx;
  logic        mmio_rsp_valid;
  t_ccip_tid   mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;
  logic        mgmt_wr, mgmt_rd;
  logic [15:0] mgmt_addr;
  logic [31:0] mgmt_wdata;
  logic [31:0] mgmt_rdata;
  logic        mgmt_rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0, rsp_delay = 5;
  bit          rsp_en = 1'b1;
  logic [31:0] rsp_data = 32'h0;
  logic [15:0] last_wr_addr, last_rd_addr;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  e2e_mmio_csr_responder #(
    .AFU_ID_L    (ID_L),
    .AFU_ID_H    (ID_H),
    .DFH_VALUE   (DFH),
    .MGMT_TIMEOUT(16)
  ) dut (
    .pClk                (clk),
    .pck_cp2af_softReset (rst),
    .pck_cp2af_sRx       (rx),
    .mmio_rsp_valid      (mmio_rsp_valid),
    .mmio_rsp_tid        (mmio_rsp_tid),
    .mmio_rsp_data       (mmio_rsp_data),
    .mgmt_wr             (mgmt_wr),
    .mgmt_rd             (mgmt_rd),
    .mgmt_addr           (mgmt_addr),
    .mgmt_wdata          (mgmt_wdata),
    .mgmt_rdata          (mgmt_rdata),
    .mgmt_rvalid         (mgmt_rvalid)
  );

  // Management bus model, evaluated mid-cycle.
  always @(negedge clk) begin
    mgmt_rvalid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        mgmt_rvalid = 1'b1;
        mgmt_rdata  = rsp_data;
      end
    end
    if (mgmt_wr) begin
      wr_cnt       = wr_cnt + 1;
      last_wr_addr = mgmt_addr;
      last_wdata   = mgmt_wdata;
    end
    if (mgmt_rd) begin
      rd_cnt       = rd_cnt + 1;
      last_rd_addr = mgmt_addr;
      if (rsp_en) rsp_cnt = rsp_delay;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mmio_wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
    @(posedge clk); #1;
    rx.c0.hdr.address = addr;
    rx.c0.hdr.length  = len;
    rx.c0.data        = {448'h0, data};
    rx.c0.mmioWrValid = 1'b1;
    @(posedge clk); #1;
    rx.c0.mmioWrValid = 1'b0;
  endtask

  // Request in cycle N; response must be a single pulse in cycle N+2.
  task automatic mmio_rd(input string tag, input logic [15:0] addr, input logic [1:0] len,
                         input logic [8:0] tid, input logic [63:0] exp);
    @(posedge clk); #1;
    rx.c0.hdr.address = addr;
    rx.c0.hdr.length  = len;
    rx.c0.hdr.tid     = tid;
    rx.c0.mmioRdValid = 1'b1;
    @(posedge clk); #1;
    rx.c0.mmioRdValid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_valid_n1"}, 64'(mmio_rsp_valid), 64'h0);
    @(negedge clk);
    check_eq({tag, "_valid_n2"}, 64'(mmio_rsp_valid), 64'h1);
    check_eq({tag, "_tid"}, 64'(mmio_rsp_tid), 64'(tid));
    check_eq({tag, "_data"}, mmio_rsp_data, exp);
    @(negedge clk);
    check_eq({tag, "_valid_n3"}, 64'(mmio_rsp_valid), 64'h0);
  endtask

  task automatic wait_rd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mgmt_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_rd_seen"}, 64'(seen), 64'h1);
  endtask

  initial begin
    int wr_snap, rd_snap;
    rx          = '0;
    mgmt_rdata  = 32'h0;
    mgmt_rvalid = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_rsp", {mmio_rsp_valid, 55'(mmio_rsp_tid)}, 64'h0);
    check_eq("reset_rsp_data", mmio_rsp_data, 64'h0);
    check_eq("reset_mgmt", {mgmt_wr, mgmt_rd, mgmt_addr, mgmt_wdata}, 64'h0);

    mmio_wr(16'h0012, 2'd1, 64'hdeef_d00f_d11f_daaf);
    mmio_rd("scratch64", 16'h0012, 2'd1, 9'h005, 64'hdeef_d00f_d11f_daaf);
    mmio_rd("dfh", 16'h0000, 2'd1, 9'h1ff, DFH);
    mmio_rd("id_l", 16'h0002, 2'd1, 9'h011, ID_L);
    mmio_rd("id_h", 16'h0004, 2'd1, 9'h012, ID_H);
    mmio_rd("unmapped15", 16'h001e, 2'd1, 9'h013, 64'h0);
    mmio_rd("scratch_hi32", 16'h0013, 2'd0, 9'h014, 64'h0000_0000_deef_d00f);
    mmio_rd("scratch_lo32", 16'h0012, 2'd0, 9'h015, 64'h0000_0000_d11f_daaf);
    mmio_rd("dfh_hi32", 16'h0001, 2'd0, 9'h016, 64'h0000_0000_1000_0000);

    // 32-bit write to the high dword takes data from [31:0] only.
    mmio_wr(16'h0013, 2'd0, 64'hffff_ffff_cafe_f00d);
    mmio_rd("scratch_w32", 16'h0012, 2'd1, 9'h020, 64'hcafe_f00d_d11f_daaf);
    mmio_wr(16'h0000, 2'd1, 64'h5a5a_5a5a_5a5a_5a5a);
    mmio_rd("dfh_ro", 16'h0000, 2'd1, 9'h021, DFH);

    // Back-to-back reads.
    @(posedge clk); #1;
    rx.c0.hdr = '{address: 16'h0012, length: 2'd1, rsvd: 1'b0, tid: 9'h001};
    rx.c0.mmioRdValid = 1'b1;
    @(posedge clk); #1;
    rx.c0.hdr = '{address: 16'h0000, length: 2'd1, rsvd: 1'b0, tid: 9'h002};
    @(posedge clk); #1;
    rx.c0.mmioRdValid = 1'b0;
    @(negedge clk);
    check_eq("b2b_first", {mmio_rsp_valid, 55'(mmio_rsp_tid)}, {1'b1, 55'h1});
    check_eq("b2b_first_data", mmio_rsp_data, 64'hcafe_f00d_d11f_daaf);
    @(negedge clk);
    check_eq("b2b_second", {mmio_rsp_valid, 55'(mmio_rsp_tid)}, {1'b1, 55'h2});
    check_eq("b2b_second_data", mmio_rsp_data, DFH);
    @(negedge clk);
    check_eq("b2b_done", 64'(mmio_rsp_valid), 64'h0);

    // Simultaneous read and write of SCRATCH: read sees the old value.
    @(posedge clk); #1;
    rx.c0.hdr = '{address: 16'h0012, length: 2'd1, rsvd: 1'b0, tid: 9'h003};
    rx.c0.data = {448'h0, 64'h1111_2222_3333_4444};
    rx.c0.mmioRdValid = 1'b1;
    rx.c0.mmioWrValid = 1'b1;
    @(posedge clk); #1;
    rx.c0.mmioRdValid = 1'b0;
    rx.c0.mmioWrValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rdwr_valid", {mmio_rsp_valid, 55'(mmio_rsp_tid)}, {1'b1, 55'h3});
    check_eq("rdwr_old_data", mmio_rsp_data, 64'hcafe_f00d_d11f_daaf);
    mmio_rd("rdwr_new", 16'h0012, 2'd1, 9'h004, 64'h1111_2222_3333_4444);

    // Indirect write, then rewrite without clearing.
    mmio_wr(16'h000e, 2'd0, 64'h0000_0000_daef_cafe);
    mmio_wr(16'h000c, 2'd1, 64'h0000_0000_0001_0000);
    repeat (4) @(negedge clk);
    check_eq("iwr_count", 64'(wr_cnt), 64'h1);
    check_eq("iwr_addr", 64'(last_wr_addr), 64'h0);
    check_eq("iwr_wdata", 64'(last_wdata), 64'h0000_0000_daef_cafe);
    mmio_wr(16'h000c, 2'd1, 64'h0000_0000_0001_0000);
    repeat (6) @(negedge clk);
    check_eq("iwr_no_rearm", 64'(wr_cnt), 64'h1);
    check_eq("iwr_no_rd", 64'(rd_cnt), 64'h0);
    mmio_rd("wdata_rb", 16'h000e, 2'd1, 9'h030, 64'h0000_0000_daef_cafe);
    mmio_rd("ctrl_after_wr", 16'h000c, 2'd1, 9'h031, 64'h0000_0000_0001_0000);

    // Indirect read answered after 5 cycles.
    mmio_wr(16'h000c, 2'd1, 64'h0);
    rsp_delay = 5;
    rsp_data  = 32'h0000_1234;
    mmio_wr(16'h000c, 2'd1, 64'h0000_0000_0002_0004);
    wait_rd("ird");
    mmio_rd("ird_busy", 16'h000c, 2'd1, 9'h040, 64'h0000_0000_8002_0004);
    repeat (10) @(posedge clk);
    check_eq("ird_addr", 64'(last_rd_addr), 64'h4);
    mmio_rd("ird_rdata", 16'h0010, 2'd1, 9'h041, 64'h0000_0000_0000_1234);
    mmio_rd("ird_idle", 16'h000c, 2'd1, 9'h042, 64'h0000_0000_0002_0004);

    // Response later than the 16-cycle timeout.
    mmio_wr(16'h000c, 2'd1, 64'h0);
    rsp_delay = 25;
    rsp_data  = 32'h0000_5555;
    mmio_wr(16'h000c, 2'd1, 64'h0000_0000_0002_0008);
    wait_rd("tmo");
    repeat (15) @(posedge clk);
    mmio_rd("tmo_last_wait", 16'h000c, 2'd1, 9'h050, 64'h0000_0000_8002_0008);
`ifdef E2E_MGMT_TIMEOUT_EN
    mmio_rd("tmo_ctrl", 16'h000c, 2'd1, 9'h051, 64'h0000_0000_4002_0008);
    repeat (5) @(posedge clk);
    mmio_rd("tmo_rdata", 16'h0010, 2'd1, 9'h052, 64'h0000_0000_dead_beef);
    mmio_wr(16'h000c, 2'd1, 64'h0);
    mmio_rd("tmo_sticky", 16'h000c, 2'd1, 9'h053, 64'h0000_0000_4000_0000);
    mmio_wr(16'h000c, 2'd1, 64'h0000_0000_0001_0000);
    repeat (3) @(posedge clk);
    mmio_rd("tmo_cleared", 16'h000c, 2'd1, 9'h054, 64'h0000_0000_0001_0000);
`else
    mmio_rd("notmo_busy", 16'h000c, 2'd1, 9'h051, 64'h0000_0000_8002_0008);
    repeat (5) @(posedge clk);
    mmio_rd("notmo_rdata", 16'h0010, 2'd1, 9'h052, 64'h0000_0000_0000_5555);
    mmio_rd("notmo_idle", 16'h000c, 2'd1, 9'h053, 64'h0000_0000_0002_0008);
`endif

    // Reset while waiting for read data.
    mmio_wr(16'h000c, 2'd1, 64'h0);
    rsp_en = 1'b0;
    mmio_wr(16'h000c, 2'd1, 64'h0000_0000_0002_0001);
    wait_rd("rst_op");
    @(posedge clk); #1;
    wr_snap = wr_cnt;
    rd_snap = rd_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_op_outs", {mmio_rsp_valid, mgmt_wr, mgmt_rd, mgmt_addr, mgmt_wdata}, 64'h0);
    check_eq("rst_op_data", mmio_rsp_data, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rst_op_strobes", {32'(wr_cnt), 32'(rd_cnt)}, {32'(wr_snap), 32'(rd_snap)});
    mmio_rd("rst_op_ctrl", 16'h000c, 2'd1, 9'h060, 64'h0);
    mmio_rd("rst_op_scratch", 16'h0012, 2'd1, 9'h061, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/e2e_mmio_csr_responder.md
Name: e2e_mmio_csr_responder

Overview:
AFU-side CCI-P MMIO responder for the eth_e2e designs.
- Decodes host MMIO reads and writes on c0 and returns read data on c2.
- Owns the AFU DFH/ID and scratch registers.
- Bridges host CSR accesses onto an indirect 32-bit management bus (CTRL/WDATA/RDATA mailbox) that reaches the E2E/MAC register space.

Parameters:
AFU_ID_L, 64'h0, low 64 bits of AFU GUID returned at register 1
AFU_ID_H, 64'h0, high 64 bits of AFU GUID returned at register 2
DFH_VALUE, 64'h1000_0000_0000_0000, value returned at register 0 (AFU DFH, EOL set)
MGMT_TIMEOUT, 1024, cycles to wait for mgmt_rvalid before aborting an indirect read

Ports:
pClk  in  1  CCI-P primary clock
pck_cp2af_softReset  in  1  synchronous active-high reset
pck_cp2af_sRx  in  t_if_ccip_Rx  CCI-P Rx; only c0.hdr, c0.data, c0.mmioRdValid and c0.mmioWrValid are used
mmio_rsp_valid  out  1  c2 mmioRdValid
mmio_rsp_tid  out  t_ccip_tid  echoed request tid
mmio_rsp_data  out  64  c2 read data
mgmt_wr  out  1  one-cycle indirect write strobe
mgmt_rd  out  1  one-cycle indirect read strobe
mgmt_addr  out  16  indirect address
mgmt_wdata  out  32  indirect write data
mgmt_rdata  in  32  indirect read data
mgmt_rvalid  in  1  indirect read data valid, at most one pulse per mgmt_rd

Behaviour:
Clock, reset and outputs
- Single clock pClk. Reset pck_cp2af_softReset is synchronous and active-high.
- Reset values: all outputs 0; SCRATCH, CTRL, WDATA, RDATA 0; FSM IDLE.

Register map (64-bit index = c0.hdr.address[15:1])
- 0 DFH (RO)
- 1 AFU_ID_L (RO)
- 2 AFU_ID_H (RO)
- 6 CTRL: [15:0] addr, [16] wr_cmd, [17] rd_cmd, [30] timeout_err (RO, sticky until the next command), [31] busy (RO)
- 7 WDATA: [31:0]
- 8 RDATA: [31:0] (RO; upper bits read 0)
- 9 SCRATCH (RW)
- Any other index: reads return 0, writes are ignored.

Access size
- length==0 means a 32-bit access: address[0] selects the dword. Writes update only that dword. Reads return the selected dword in [31:0] with [63:32]=0.
- Any other length is a 64-bit access.

Read path
- Request sampled at cycle N; mmio_rsp_valid pulses for exactly 1 cycle at N+2 with the tid echoed.
- Fully pipelined: back-to-back reads on consecutive cycles produce consecutive responses in order.
- Simultaneous rd+wr in the same cycle: both are processed, and the read returns the pre-write value.

Indirect FSM: IDLE, WR, RD_REQ, RD_WAIT
- IDLE->WR on a CTRL write where stored wr_cmd goes 0->1. In WR: mgmt_wr=1 for 1 cycle with mgmt_addr=CTRL[15:0] and mgmt_wdata=WDATA, then return to IDLE.
- IDLE->RD_REQ on a CTRL write where rd_cmd goes 0->1. In RD_REQ: mgmt_rd=1 for 1 cycle, then go to RD_WAIT.
- RD_WAIT->IDLE on mgmt_rvalid: RDATA<=mgmt_rdata.
- Both bits rising in the same write: the write is performed and rd is ignored.
- Commands are edge-triggered on the stored bits; the host writes 0 to re-arm.
- busy=1 whenever the FSM is not IDLE. CTRL writes while busy update the stored fields but do not start a command.
- mgmt_rvalid outside RD_WAIT is ignored.
- Reset mid-operation aborts immediately; no further strobes are issued.

Optional Feature:
E2E_MGMT_TIMEOUT_EN
- Defined: a counter runs in RD_WAIT. After MGMT_TIMEOUT cycles without mgmt_rvalid: RDATA<=32'hDEAD_BEEF, timeout_err<=1, FSM returns to IDLE.
- Undefined: RD_WAIT waits indefinitely, and timeout_err reads 0.

Decomposition:
Package e2e_csr_pkg:
- register index localparams (E2E_CSR_DFH=0 through E2E_CSR_SCRATCH=9)
- CTRL bit-position localparams
- FSM state enum t_mgmt_state
- TIMEOUT_PATTERN constant
One sub-module, e2e_mgmt_indirect_fsm: the IDLE/WR/RD_REQ/RD_WAIT FSM plus the timeout counter. The top level holds register decode and the read pipeline.

Test Plan:
- Write SCRATCH(9) = 64'hdeefd00fd11fdaaf, then read 9 -> response 2 cycles after the request, data matches, tid echoed.
- Read 0/1/2 -> DFH_VALUE/AFU_ID_L/AFU_ID_H; read index 15 -> 0; 32-bit read at address 0x13 (reg 9 high dword) -> 32'hdeefd00f.
- WDATA=32'hDAEFCAFE, CTRL=0x10000 -> single mgmt_wr pulse with addr 0, wdata DAEFCAFE; CTRL=0x10000 rewritten without clearing -> no second pulse.
- CTRL=0x20004, model returns mgmt_rvalid after 5 cycles with 32'h1234 -> busy=1 during the wait, RDATA reads 32'h1234, busy=0 afterwards.
- E2E_MGMT_TIMEOUT_EN defined, MGMT_TIMEOUT=16, no rvalid -> after 16 cycles RDATA=DEADBEEF and CTRL[30]=1; a late rvalid is ignored.
- Assert reset during RD_WAIT -> all outputs 0 on the next cycle, no mgmt strobes; reading CTRL afterwards returns 0.
